pin_check_monitor: RTL and testbench
====================================

// Module: pin_check_monitor
// PURPOSE
//  Checks the pad-level pins PIN1..PIN4 against a stream of expected values
//  while test-module checking is enabled. The enable comes from the force_value_to_1 /
//  force_value_to_0 tasks, which drive check_en. Each pin value is synchronised,
//  compared under a mask, and counted. Mismatches are logged as sticky per-pin flags and a saturating count.
//  Sits directly downstream of the pin-level test module and feeds the bench scoreboard.
// PARAMETERS
//  NPINS        4   number of monitored pins (PIN1..PIN4 -> pin_in[0..3])
//  SYNC_STAGES  2   synchroniser depth on pin_in, legal 2..4
//  SETTLE_CYC   8   cycles waited after enable before comparisons start, legal 1..255
//  CNT_W        8   width of mismatch_cnt and check_cnt
// PORTS
//  clk           in   1      single clock; all logic on posedge
//  reset         in   1      synchronous, active-high reset
//  check_en      in   1      test-module checking enable (level)
//  pin_in        in   NPINS  sampled pin levels (async to clk)
//  exp_valid     in   1      expected-value beat valid
//  exp_data      in   NPINS  expected pin levels
//  exp_mask      in   NPINS  1 = compare this pin, 0 = don't care
//  exp_ready     out  1      monitor accepts expected beat
//  busy          out  1      state is SETTLE or CHECK
//  done          out  1      state is HOLD (results frozen)
//  err_flag      out  1      sticky: any mismatch since last arm
//  err_pins      out  NPINS  sticky OR of per-pin mismatches
//  mismatch_cnt  out  CNT_W  saturating mismatch-beat count
//  check_cnt     out  CNT_W  saturating accepted-beat count
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: exp_ready, busy, done, err_flag, err_pins, mismatch_cnt, check_cnt.
//    Synchroniser flops and the check_en edge register are also 0. Reset wins over every other event, including mid-CHECK.
//  - pin_sync = pin_in after SYNC_STAGES flops. Comparisons use pin_sync only.
//  - rise = check_en & ~check_en_q, where check_en_q is a 1-cycle registered copy of check_en.
//  - FSM (all outputs registered; they reflect state one cycle after the transition):
//    IDLE  : rise -> SETTLE; clear err_flag, err_pins, mismatch_cnt, check_cnt; load settle counter.
//    SETTLE: counter decrements each cycle; after SETTLE_CYC cycles in SETTLE -> CHECK.
//            check_en=0 in SETTLE -> HOLD (counts remain 0).
//    CHECK : exp_ready=1. Accept when exp_valid&exp_ready.
//            diff = (pin_sync ^ exp_data) & exp_mask.
//            check_cnt++. If diff!=0: mismatch_cnt++, err_pins|=diff, err_flag=1.
//            check_en=0 -> HOLD. A beat accepted in that same cycle still counts.
//    HOLD  : exp_ready=0, done=1, results frozen. rise -> SETTLE with the same clears as IDLE.
//  - exp_ready is deasserted in every state except CHECK. exp_valid outside CHECK is ignored (no stall, no count).
//  - Counters saturate at 2^CNT_W-1 and never wrap. err_pins keeps accumulating after saturation.
//  - exp_mask=0 beat: counted in check_cnt, can never mismatch.
//  - check_en held high through HOLD: no re-arm. A new arm requires a fresh 0->1 edge.
//  - Latency: pin change to compare-visible = SYNC_STAGES cycles.
//    Accepted beat to mismatch_cnt/err_* update = 1 cycle.
// TESTING
//  1 reset mid-CHECK with mismatch_cnt=3 -> next cycle IDLE, all outputs 0, exp_ready=0.
//  2 check_en 0->1, pin_in=4'b1010 stable; after SETTLE_CYC=8 exp_ready=1.
//    Send exp_data=4'b1010, mask=4'hF x5 -> check_cnt=5, mismatch_cnt=0, err_flag=0.
//  3 pin_in=4'b1011, exp_data=4'b1010: mask=4'hF -> err_pins=4'b0001, mismatch_cnt=1.
//    Same beat with mask=4'hE -> no mismatch.
//  4 CNT_W=4, 20 mismatching beats -> mismatch_cnt=15 and check_cnt=15 (both held), err_flag=1.
//  5 check_en 1->0 in the same cycle as an accepted mismatching beat -> beat counted.
//    done=1 next cycle; exp_valid afterwards has no effect.
//  6 In HOLD, check_en 0->1 -> counters and err_* clear, busy=1, SETTLE_CYC cycles before exp_ready=1.
//    check_en=0 during SETTLE -> HOLD with check_cnt=0.

Source files
------------

// File: rtl/pin_check_monitor.sv
// pin_check_monitor: compares synchronised pad pins against a stream of
// expected beats while checking is enabled. It records sticky per-pin error
// flags and keeps saturating counts of accepted beats and mismatching beats.
//
// Ports:
//   clk          in   single clock, posedge
//   reset        in   synchronous active-high reset
//   check_en     in   checking enable level; a 0->1 edge arms the monitor
//   pin_in       in   raw pin levels (asynchronous to clk)
//   exp_valid    in   expected beat valid
//   exp_data     in   expected pin levels
//   exp_mask     in   per-pin compare enable
//   exp_ready    out  beat accepted this cycle when high with exp_valid
//   busy         out  settling or checking
//   done         out  checking finished, results frozen
//   err_flag     out  sticky: any mismatch since the last arm
//   err_pins     out  sticky OR of per-pin mismatches
//   mismatch_cnt out  saturating count of mismatching beats
//   check_cnt    out  saturating count of accepted beats
module pin_check_monitor #(
  parameter int unsigned NPINS       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_en,
  input  logic [NPINS-1:0] pin_in,
  input  logic             exp_valid,
  input  logic [NPINS-1:0] exp_data,
  input  logic [NPINS-1:0] exp_mask,
  output logic             exp_ready,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [NPINS-1:0] err_pins,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] check_cnt
);

  localparam int unsigned SET_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q, sync_d;
  logic                          check_en_q, check_en_d;
  logic [SET_W-1:0]              settle_q, settle_d;
  logic                          exp_ready_q, exp_ready_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          err_flag_q, err_flag_d;
  logic [NPINS-1:0]              err_pins_q, err_pins_d;
  logic [CNT_W-1:0]              mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0]              check_cnt_q, check_cnt_d;

  logic             rise;
  logic             accept;
  logic [NPINS-1:0] pin_sync;
  logic [NPINS-1:0] diff;

  // Synchroniser shift chain: stage 0 captures the raw pins.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pin_in};
    check_en_d = check_en;
  end

  assign pin_sync = sync_q[SYNC_STAGES-1];
  assign rise     = check_en & ~check_en_q;
  assign accept   = exp_valid & exp_ready_q;
  assign diff     = (pin_sync ^ exp_data) & exp_mask;

  // Next state, result updates and registered outputs.
  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    err_flag_d     = err_flag_q;
    err_pins_d     = err_pins_q;
    mismatch_cnt_d = mismatch_cnt_q;
    check_cnt_d    = check_cnt_q;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (rise) begin
          state_d        = ST_SETTLE;
          settle_d       = SET_W'(SETTLE_CYC - 1);
          err_flag_d     = 1'b0;
          err_pins_d     = '0;
          mismatch_cnt_d = '0;
          check_cnt_d    = '0;
        end
      end
      ST_SETTLE: begin
        // Losing the enable while settling ends the session with empty results.
        if (!check_en) begin
          state_d = ST_HOLD;
        end else if (settle_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_CHECK: begin
        // A beat accepted in the same cycle the enable drops still counts.
        if (accept) begin
          if (check_cnt_q != CNT_MAX) check_cnt_d = check_cnt_q + CNT_W'(1);
          if (diff != '0) begin
            if (mismatch_cnt_q != CNT_MAX) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
            err_pins_d = err_pins_q | diff;
            err_flag_d = 1'b1;
          end
        end
        if (!check_en) state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase

    exp_ready_d = (state_d == ST_CHECK);
    busy_d      = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d      = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sync_q         <= '0;
      check_en_q     <= 1'b0;
      settle_q       <= '0;
      exp_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_flag_q     <= 1'b0;
      err_pins_q     <= '0;
      mismatch_cnt_q <= '0;
      check_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      check_en_q     <= check_en_d;
      settle_q       <= settle_d;
      exp_ready_q    <= exp_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_flag_q     <= err_flag_d;
      err_pins_q     <= err_pins_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      check_cnt_q    <= check_cnt_d;
    end
  end

  assign exp_ready    = exp_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_flag     = err_flag_q;
  assign err_pins     = err_pins_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign check_cnt    = check_cnt_q;

endmodule

// File: tb/tb_pin_check_monitor.sv
// Bench for pin_check_monitor: random and directed pin/expected streams,
// with a scoreboard of predicted results popped on every accepted beat.
module tb_pin_check_monitor;

  localparam int unsigned NP   = 4;
  localparam int unsigned SS   = 2;
  localparam int unsigned SC   = 8;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          check_en;
  logic [NP-1:0] pin_in;
  logic          exp_valid;
  logic [NP-1:0] exp_data;
  logic [NP-1:0] exp_mask;
  logic          exp_ready;
  logic          busy;
  logic          done;
  logic          err_flag;
  logic [NP-1:0] err_pins;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] check_cnt;

  pin_check_monitor #(
    .NPINS(NP), .SYNC_STAGES(SS), .SETTLE_CYC(SC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .check_en(check_en), .pin_in(pin_in),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_mask(exp_mask),
    .exp_ready(exp_ready), .busy(busy), .done(done), .err_flag(err_flag),
    .err_pins(err_pins), .mismatch_cnt(mismatch_cnt), .check_cnt(check_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] cc;
    logic [CW-1:0] mc;
    logic          ef;
    logic [NP-1:0] ep;
  } snap_t;

  snap_t sbq[$];

  int total = 0;
  int bad   = 0;

  // Reference state: results of the current session and the pin level held.
  int          m_cc;
  int          m_mc;
  bit          m_ef;
  bit [NP-1:0] m_ep;
  bit [NP-1:0] pins;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_cc = 0; m_mc = 0; m_ef = 1'b0; m_ep = '0;
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_check_cnt"}, 32'(check_cnt), 32'(m_cc));
    chk({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_mc));
    chk({tag, "_err_flag"}, 32'(err_flag), 32'(m_ef));
    chk({tag, "_err_pins"}, 32'(err_pins), 32'(m_ep));
  endtask

  // Drive pins and wait exactly the synchroniser depth before comparing.
  task automatic set_pins(input logic [NP-1:0] p);
    pin_in = p;
    pins   = p;
    repeat (SS) cyc();
  endtask

  // Issue one beat the monitor is expected to accept; optionally drop enable with it.
  task automatic send(input logic [NP-1:0] d, input logic [NP-1:0] m, input bit drop_en);
    bit [NP-1:0] df;
    snap_t       s;
    exp_valid = 1'b1;
    exp_data  = d;
    exp_mask  = m;
    if (drop_en) check_en = 1'b0;
    df = (pins ^ d) & m;
    if (m_cc < MAXC) m_cc++;
    if (df != '0) begin
      if (m_mc < MAXC) m_mc++;
      m_ep = m_ep | df;
      m_ef = 1'b1;
    end
    s.cc = CW'(m_cc); s.mc = CW'(m_mc); s.ef = m_ef; s.ep = m_ep;
    sbq.push_back(s);
    cyc();
    exp_valid = 1'b0;
  endtask

  // Fresh 0->1 enable edge, then confirm the settle window length.
  task automatic arm(input string tag);
    check_en = 1'b0;
    cyc();
    check_en = 1'b1;
    model_clear();
    for (int k = 0; k < int'(SC); k++) begin
      cyc();
      if (k == 0) begin
        chk_results({tag, "_arm_clear"});
        chk({tag, "_arm_busy"}, 32'(busy), 32'd1);
        chk({tag, "_arm_done"}, 32'(done), 32'd0);
      end
      chk({tag, "_settle_ready"}, 32'(exp_ready), 32'd0);
    end
    cyc();
    chk({tag, "_check_ready"}, 32'(exp_ready), 32'd1);
    chk({tag, "_check_busy"}, 32'(busy), 32'd1);
  endtask

  // Monitor: inputs are stable at negedge, so handshake there predicts the next edge.
  bit fire_prev = 1'b0;
  always @(negedge clk) begin
    snap_t s;
    if (fire_prev) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_accept: got 1 want 0");
      end else begin
        s = sbq.pop_front();
        chk("sb_check_cnt", 32'(check_cnt), 32'(s.cc));
        chk("sb_mismatch_cnt", 32'(mismatch_cnt), 32'(s.mc));
        chk("sb_err_flag", 32'(err_flag), 32'(s.ef));
        chk("sb_err_pins", 32'(err_pins), 32'(s.ep));
      end
    end
    fire_prev = !reset && exp_valid && exp_ready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; check_en = 1'b0; pin_in = '0; pins = '0;
    exp_valid = 1'b0; exp_data = '0; exp_mask = '0;
    model_clear();
    repeat (3) cyc();
    chk("rst_ready", 32'(exp_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_results("rst");
    reset = 1'b0;
    cyc();
    chk("idle_busy", 32'(busy), 32'd0);

    // Stable matching pins, full mask.
    arm("a1");
    set_pins(4'b1010);
    repeat (5) send(4'b1010, 4'hF, 1'b0);
    repeat (2) cyc();
    chk("match5_check_cnt", 32'(check_cnt), 32'd5);
    chk("match5_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    chk("match5_err_flag", 32'(err_flag), 32'd0);

    // Single-pin mismatch, then the same beat with that pin masked off.
    set_pins(4'b1011);
    send(4'b1010, 4'hF, 1'b0);
    send(4'b1010, 4'hE, 1'b0);
    send(4'b1111, 4'h0, 1'b0);
    repeat (2) cyc();
    chk("pin0_err_pins", 32'(err_pins), 32'b0001);
    chk("pin0_mismatch_cnt", 32'(mismatch_cnt), 32'd1);
    chk("pin0_check_cnt", 32'(check_cnt), 32'd8);

    // Randomized beats, pin changes and idle gaps.
    arm("rnd");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) set_pins(NP'($urandom));
      if ($urandom_range(0, 3) == 0) cyc();
      send(NP'($urandom), ($urandom_range(0, 4) == 0) ? NP'(0) : NP'($urandom), 1'b0);
    end
    repeat (2) cyc();
    chk_results("rnd_end");

    // Saturation of both counters.
    arm("sat");
    set_pins(4'b0000);
    repeat (20) send(4'hF, 4'hF, 1'b0);
    repeat (2) cyc();
    chk("sat_mismatch_cnt", 32'(mismatch_cnt), 32'd15);
    chk("sat_check_cnt", 32'(check_cnt), 32'd15);
    chk("sat_err_flag", 32'(err_flag), 32'd1);
    chk("sat_err_pins", 32'(err_pins), 32'hF);

    // Enable drops together with an accepted mismatching beat.
    arm("drop");
    set_pins(4'b0110);
    send(4'b0110, 4'hF, 1'b0);
    send(4'b0110, 4'hF, 1'b0);
    send(4'b0100, 4'hF, 1'b1);
    chk("drop_done", 32'(done), 32'd1);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_ready", 32'(exp_ready), 32'd0);
    exp_valid = 1'b1; exp_data = 4'h9; exp_mask = 4'hF;
    repeat (3) cyc();
    exp_valid = 1'b0;
    cyc();
    chk("hold_check_cnt", 32'(check_cnt), 32'd3);
    chk("hold_mismatch_cnt", 32'(mismatch_cnt), 32'd1);
    chk("hold_err_pins", 32'(err_pins), 32'b0010);
    chk_results("hold");

    // Re-arm from HOLD, then abort during settle.
    arm("rearm");
    check_en = 1'b0;
    cyc();
    check_en = 1'b1;
    model_clear();
    repeat (3) cyc();
    chk("abort_busy", 32'(busy), 32'd1);
    check_en = 1'b0;
    cyc();
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_check_cnt", 32'(check_cnt), 32'd0);

    // Reset in the middle of checking.
    arm("mid");
    set_pins(4'b1100);
    repeat (3) send(4'b0011, 4'hF, 1'b0);
    repeat (2) cyc();
    chk("mid_mismatch_cnt", 32'(mismatch_cnt), 32'd3);
    reset = 1'b1;
    check_en = 1'b0;
    model_clear();
    cyc();
    chk("midrst_ready", 32'(exp_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk_results("midrst");
    reset = 1'b0;
    repeat (2) cyc();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
